p0008_bcd_out: RTL and testbench
================================

# p0008_bcd_out

Downstream stage of the p0008 solver. Captures the solver's 46-bit binary result when the solver asserts done or error. Converts that result to packed BCD with an iterative shift-add-3 (double-dabble) engine and reports the count of significant decimal digits. Its outputs feed the display/report path, and the bench compares them directly against known answers.

## Interface
Parameters:
- BIN_W, 46: width of the binary input.
- DIGITS, 14: number of BCD nibbles produced. Must satisfy DIGITS ≥ ceil(BIN_W·log10(2)); the defaults are exact (2^46−1 = 70368744177663).
- CNT_W, $clog2(DIGITS+1): width of ndigits.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, driven by the solver's done.
- err_in  in  1  solver error flag, sampled together with start.
- bin_in  in  BIN_W  solver result, sampled when start is accepted.
- busy  out  1  conversion in progress.
- valid  out  1  bcd_out, ndigits and error are stable and meaningful.
- error  out  1  the captured job carried err_in.
- bcd_out  out  4·DIGITS  packed BCD, most significant digit in the top nibble.
- ndigits  out  CNT_W  number of significant digits; 1 for the value 0.

## Operation
- States: IDLE, SHIFT, TRIM, DONE.
- Reset: state IDLE. busy, valid and error are 0. bcd_out and ndigits are 0.
- IDLE or DONE with start=1 and err_in=0:
  - latch bin_in into the shift register;
  - clear the BCD accumulator, set the step counter to BIN_W;
  - clear valid and set busy;
  - go to SHIFT.
- IDLE or DONE with start=1 and err_in=1:
  - go directly to DONE;
  - valid=1, error=1, bcd_out=0, ndigits=0, busy stays 0.
- SHIFT, once per cycle:
  - every accumulator nibble ≥5 gets +3;
  - then {accumulator, binary} shifts left by 1;
  - the counter decrements;
  - after the BIN_W-th step, go to TRIM.
- TRIM, one cycle:
  - register bcd_out from the accumulator;
  - ndigits = 1 + index of the highest nonzero nibble, or 1 if all nibbles are zero;
  - set valid, clear busy and error;
  - go to DONE.
- DONE holds all outputs until the next accepted start or rst.
- start while busy (SHIFT or TRIM) is ignored. There is no queueing, and the in-flight job is unaffected.
- rst at any time, including mid-SHIFT, returns the block to the reset values on the next edge. The partial result is discarded.
- Arithmetic: the add-3 is applied per nibble and never carries between nibbles. Under the DIGITS rule above, no nibble can exceed 9 after any step.

## Timing
- start is accepted on edge E0, and busy=1 after E0.
- The shift steps run on edges E1..E_BIN_W. TRIM runs on edge E_(BIN_W+1).
- valid=1 after edge E_(BIN_W+1), which is 47 cycles with the defaults, and busy falls on the same edge.
- Error path: valid=1 and error=1 one edge after the accepting edge.
- valid falls on the edge that accepts a new start. It is never high while busy is high.
- Back-to-back jobs: a start arriving in the first DONE cycle is accepted, so there are no dead cycles.

## Structure
- Shared package euler_pkg holds:
  - the constants P0008_BIN_W=46 and P0008_DIGITS=14;
  - the state enum {IDLE, SHIFT, TRIM, DONE};
  - a function computing the minimum DIGITS for a given BIN_W, used by a parameter-check assertion.
- One sub-module, bcd_add3: combinational, takes a 4-bit nibble and returns nibble+3 when ≥5, otherwise the nibble unchanged. It is instantiated DIGITS times via generate.
- The leading-digit priority encoder stays inline in the TRIM logic.

## Test plan
- bin_in=0, start pulse → after 47 cycles: valid=1, bcd_out=0, ndigits=1, error=0.
- bin_in=23514624000 (p0008 answer) → bcd_out=0x00023514624000, ndigits=11, valid exactly 47 cycles after start.
- bin_in=2^46−1 → bcd_out=0x70368744177663, ndigits=14.
- start with err_in=1 → next cycle: valid=1, error=1, bcd_out=0, ndigits=0; busy never asserts.
- start at cycle 0, second start at cycle 10 with a different value → second start ignored; result matches the first value; then rst asserted at cycle 20 of a fresh job → all outputs 0 and state IDLE next edge.
- Two jobs back-to-back (9 then 10), second start in the first DONE cycle → valid drops for 47 cycles; results ndigits=1 then ndigits=2, bcd_out=0x...10.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared definitions for the Euler solver pipeline: p0008 sizing constants,
// the BCD output FSM state type and a sizing helper for BCD conversion.
package euler_pkg;

  localparam int P0008_BIN_W  = 46;
  localparam int P0008_DIGITS = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRIM  = 2'd2,
    DONE  = 2'd3
  } bcd_state_t;

  // ceil(bin_w * log10(2)), with log10(2) approximated as 0.30103
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: a value of 5 or more gets +3,
// so that the following left shift carries into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adj
);

  assign adj = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/p0008_bcd_out.sv
// Captures the p0008 solver result and converts it to packed BCD with an
// iterative shift-add-3 engine, reporting the count of significant digits.
module p0008_bcd_out
  import euler_pkg::*;
#(
  parameter int BIN_W  = P0008_BIN_W,
  parameter int DIGITS = P0008_DIGITS,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  err_in,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic                  error,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [CNT_W-1:0]      ndigits
);

  localparam int  STEP_W    = $clog2(BIN_W + 1);
  localparam bit  DIGITS_OK = (DIGITS >= min_digits(BIN_W));

  bcd_state_t             state_reg;
  logic [BIN_W-1:0]       bin_reg;
  logic [4*DIGITS-1:0]    acc_reg;
  logic [4*DIGITS-1:0]    acc_adj;
  logic [STEP_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]       lead_cnt;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .nibble (acc_reg[4*gi +: 4]),
        .adj    (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Highest nonzero nibble wins; an all-zero accumulator still reports one digit.
  always_comb begin
    lead_cnt = CNT_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_reg[4*i +: 4] != 4'd0) begin
        lead_cnt = CNT_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      error     <= 1'b0;
      bcd_out   <= '0;
      ndigits   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (err_in) begin
              state_reg <= DONE;
              valid     <= 1'b1;
              error     <= 1'b1;
              bcd_out   <= '0;
              ndigits   <= '0;
              busy      <= 1'b0;
            end else begin
              state_reg <= SHIFT;
              bin_reg   <= bin_in;
              acc_reg   <= '0;
              cnt_reg   <= STEP_W'(BIN_W);
              valid     <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          {acc_reg, bin_reg} <= {acc_adj, bin_reg} << 1;
          cnt_reg            <= cnt_reg - STEP_W'(1);
          if (cnt_reg == STEP_W'(1)) begin
            state_reg <= TRIM;
          end
        end
        TRIM: begin
          bcd_out   <= acc_reg;
          ndigits   <= lead_cnt;
          valid     <= 1'b1;
          busy      <= 1'b0;
          error     <= 1'b0;
          state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  digits_ok_a: assert property (@(posedge clk) disable iff (rst) DIGITS_OK);

endmodule

// File: tb/tb_p0008_bcd_out.sv
// Directed-vector bench for p0008_bcd_out: known conversions, error path,
// start-while-busy, mid-job reset and back-to-back jobs.
module tb_p0008_bcd_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        err_in;
  logic [45:0] bin_in;
  logic        busy;
  logic        valid;
  logic        error;
  logic [55:0] bcd_out;
  logic [3:0]  ndigits;

  int n_cmp = 0;
  int n_bad = 0;
  int cycles;

  p0008_bcd_out dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .err_in  (err_in),
    .bin_in  (bin_in),
    .busy    (busy),
    .valid   (valid),
    .error   (error),
    .bcd_out (bcd_out),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic pulse_start(input logic [45:0] val, input logic err);
    start  = 1'b1;
    err_in = err;
    bin_in = val;
    tick();
    start  = 1'b0;
    err_in = 1'b0;
  endtask

  // Counts edges after the accepting edge until valid rises (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic run_job(input string tag, input logic [45:0] val,
                         input logic [55:0] exp_bcd, input logic [3:0] exp_nd);
    int n;
    pulse_start(val, 1'b0);
    chk({tag, " busy after accept"}, 64'(busy), 64'd1);
    chk({tag, " valid after accept"}, 64'(valid), 64'd0);
    wait_valid(n);
    chk({tag, " latency"}, 64'(n), 64'd47);
    chk({tag, " busy at valid"}, 64'(busy), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
    chk({tag, " bcd_out"}, 64'(bcd_out), 64'(exp_bcd));
    chk({tag, " ndigits"}, 64'(ndigits), 64'(exp_nd));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    err_in = 1'b0;
    bin_in = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    chk("reset bcd_out", 64'(bcd_out), 64'd0);
    chk("reset ndigits", 64'(ndigits), 64'd0);

    run_job("zero", 46'd0, 56'h0, 4'd1);
    tick();
    run_job("p0008", 46'd23514624000, 56'h00023514624000, 4'd11);
    tick();
    run_job("max", 46'h3FFF_FFFF_FFFF, 56'h70368744177663, 4'd14);

    // Error job: reported on the very next edge, busy never rises
    pulse_start(46'd12345, 1'b1);
    chk("err valid", 64'(valid), 64'd1);
    chk("err error", 64'(error), 64'd1);
    chk("err bcd_out", 64'(bcd_out), 64'd0);
    chk("err ndigits", 64'(ndigits), 64'd0);
    chk("err busy", 64'(busy), 64'd0);
    tick();
    chk("err hold valid", 64'(valid), 64'd1);
    chk("err hold busy", 64'(busy), 64'd0);

    // Second start while busy must be ignored
    pulse_start(46'd123, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    pulse_start(46'd999, 1'b0);
    chk("ignore busy", 64'(busy), 64'd1);
    wait_valid(cycles);
    chk("ignore latency", 64'(cycles + 10), 64'd47);
    chk("ignore bcd_out", 64'(bcd_out), 64'h123);
    chk("ignore ndigits", 64'(ndigits), 64'd3);
    chk("ignore error", 64'(error), 64'd0);

    // Reset in the middle of a fresh job discards it
    pulse_start(46'd5, 1'b0);
    for (int i = 0; i < 19; i++) tick();
    chk("midrst busy before", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst valid", 64'(valid), 64'd0);
    chk("midrst error", 64'(error), 64'd0);
    chk("midrst bcd_out", 64'(bcd_out), 64'd0);
    chk("midrst ndigits", 64'(ndigits), 64'd0);
    tick();
    chk("midrst stays idle", 64'(busy), 64'd0);

    // Back-to-back: second start lands in the first DONE cycle
    run_job("b2b first", 46'd9, 56'h9, 4'd1);
    run_job("b2b second", 46'd10, 56'h10, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
